sysarr_ctrl: RTL and testbench
==============================

// Module: sysarr_ctrl
// PURPOSE
//  Sequencer for the weight-stationary systolic array (ARRAY_N x ARRAY_N PE grid).
//  Per job: loads weights row by row, streams NUM_VEC input vectors with column skew,
//  and flags right-edge partial sums as valid with row skew. Sits between the
//  weight/activation SRAM buffers and the PE grid; issues no arithmetic itself.
// PARAMETERS
//  ARRAY_N   32  PE rows = PE columns
//  VEC_AW    10  activation-buffer address width (max vectors per job = 2**VEC_AW)
//  W_AW       5  weight-buffer address width (>= clog2(ARRAY_N))
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        synchronous reset, active-high
//  start        in   1        1-cycle job request; sampled only in IDLE
//  num_vec      in   VEC_AW+1 vectors in job, sampled with start; 0 = weight load only
//  busy         out  1        high from cycle after accepted start until DONE exits
//  done         out  1        1-cycle pulse, last psum has left the array
//  w_rd_en      out  1        weight-buffer read strobe
//  w_rd_addr    out  W_AW     weight row address
//  we_rl        out  ARRAY_N  per-row weight reload (one-hot), to PE row r
//  x_rd_en      out  1        activation-buffer read strobe
//  x_rd_addr    out  VEC_AW   activation vector address
//  col_vld      out  ARRAY_N  col j: DIN at top of column j is valid
//  row_out_vld  out  ARRAY_N  row i: PSUM_OUT at right edge of row i is valid
//  perf_cycles  out  32       busy-cycle count of last job (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0; skew lines cleared.
//  FSM: IDLE -> WLOAD -> STREAM -> DRAIN -> DONE -> IDLE.
//   IDLE: start=1 latches num_vec, -> WLOAD. start while not IDLE ignored (no queue).
//   WLOAD: ARRAY_N cycles, w_rd_en=1, w_rd_addr=0..ARRAY_N-1. Buffer read latency 1:
//     we_rl[r] pulses exactly one cycle after the read of row r (one-hot, never two bits).
//     After last read: -> STREAM if num_vec!=0, else -> DONE (after last we_rl pulse).
//   STREAM: num_vec cycles, x_rd_en=1, x_rd_addr=0..num_vec-1. First read issued the
//     cycle after we_rl[ARRAY_N-1] pulses (weights settled before any DIN).
//     base_vld = x_rd_en delayed 1 cycle (buffer latency).
//     col_vld[j]   = base_vld delayed j cycles (column skew).
//     row_out_vld[i] = base_vld delayed ARRAY_N+i cycles (psum exits row i after
//     i DIN hops + ARRAY_N-1 psum hops + output register).
//   DRAIN: waits until all skew lines empty (row_out_vld[ARRAY_N-1] last high), -> DONE.
//     Drain length = 2*ARRAY_N cycles after last x_rd_en; counted, not inferred.
//   DONE: done=1 one cycle, busy drops with it next cycle; -> IDLE.
//  Widths: vector counter VEC_AW+1 bits so num_vec=2**VEC_AW does not wrap;
//   x_rd_addr = counter[VEC_AW-1:0]. num_vec > 2**VEC_AW: clamp to 2**VEC_AW.
//  Back-to-back: start in the cycle done=1 is ignored; earliest accept is IDLE cycle.
//  Reset mid-job: all strobes and vld bits drop the cycle after rst; no done pulse.
//  PE grid has no enable; ctrl never stalls. Buffers guarantee data on every strobe.
// CONFIGURATION
//  SYSARR_CTRL_PERF_EN defined: 32-bit counter increments every busy cycle, cleared on
//   accepted start, held after DONE; perf_cycles reads it (saturates at 2**32-1).
//  Undefined: counter not built, perf_cycles tied to 0.
// STRUCTURE
//  sysarr_pkg: ARRAY_N, VEC_AW, W_AW defaults, state enum
//   (IDLE/WLOAD/STREAM/DRAIN/DONE), DRAIN_CYC = 2*ARRAY_N localparam.
//  Sub-module skew_line #(DEPTH): 1-bit shift register with per-tap outputs and sync
//   clear; one instance of depth 2*ARRAY_N feeds col_vld and row_out_vld taps.
// TESTING
//  Reset: rst=1 3 cycles mid-STREAM -> all outputs 0 next cycle, state IDLE, no done.
//  N=4, start num_vec=0 -> w_rd_addr 0..3, we_rl 0001,0010,0100,1000 lagged 1, done, no x_rd_en.
//  N=4, num_vec=3 -> x_rd_addr 0,1,2; col_vld[3] high 3 cycles starting 4 after first
//   x_rd_en; row_out_vld[3] high 3 cycles starting 8 after; done 1 cycle after drain.
//  start pulsed during STREAM and in done cycle -> ignored; second start in IDLE accepted.
//  num_vec=2**VEC_AW -> addresses 0..2**VEC_AW-1 exactly once, no wrap; done asserted.
//  SYSARR_CTRL_PERF_EN, N=4, num_vec=3 -> perf_cycles equals busy-high cycle count.

Source files
------------

// File: rtl/sysarr_pkg.sv
// Shared defaults, FSM state type and small helpers for the systolic-array sequencer.
package sysarr_pkg;

  localparam int DEF_ARRAY_N = 32;
  localparam int DEF_VEC_AW  = 10;
  localparam int DEF_W_AW    = 5;

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    STREAM,
    DRAIN,
    DONE
  } state_e;

  function automatic int drain_cycles(input int n);
    return 2 * n;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int DRAIN_CYC = drain_cycles(DEF_ARRAY_N);

endpackage

// File: rtl/sysarr_ctrl_skew_line.sv
// 1-bit shift register exposing every tap; tap k is the input delayed k+1 cycles.
module skew_line #(
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             d_i,
  output logic [DEPTH-1:0] taps_o
);

  logic [DEPTH-1:0] sr_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= {sr_q[DEPTH-2:0], d_i};
    end
  end

  assign taps_o = sr_q;

endmodule

// File: rtl/sysarr_ctrl.sv
// Weight-stationary systolic-array sequencer: weight load, skewed vector streaming, drain.
// Optional busy-cycle counter enabled by defining SYSARR_CTRL_PERF_EN.
module sysarr_ctrl
  import sysarr_pkg::*;
#(
  parameter int ARRAY_N = DEF_ARRAY_N,
  parameter int VEC_AW  = DEF_VEC_AW,
  parameter int W_AW    = DEF_W_AW
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [VEC_AW:0]    num_vec_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               w_rd_en_o,
  output logic [W_AW-1:0]    w_rd_addr_o,
  output logic [ARRAY_N-1:0] we_rl_o,
  output logic               x_rd_en_o,
  output logic [VEC_AW-1:0]  x_rd_addr_o,
  output logic [ARRAY_N-1:0] col_vld_o,
  output logic [ARRAY_N-1:0] row_out_vld_o,
  output logic [31:0]        perf_cycles_o
);

  localparam int DRAIN_LEN = drain_cycles(ARRAY_N);
  localparam int CNT_W     = max_int(VEC_AW + 1, max_int($clog2(DRAIN_LEN) + 1, W_AW + 1));

  localparam logic [VEC_AW:0]  MAX_VEC    = {1'b1, {VEC_AW{1'b0}}};
  localparam logic [CNT_W-1:0] WLOAD_LAST = CNT_W'(ARRAY_N);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_LEN - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [VEC_AW:0]      nv_q, nv_d;
  logic [ARRAY_N-1:0]   we_rl_q, we_rl_d;
  logic [CNT_W-1:0]     nv_last;
  logic [2*ARRAY_N-1:0] taps;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nv_q    <= '0;
      we_rl_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nv_q    <= nv_d;
      we_rl_q <= we_rl_d;
    end
  end

  assign nv_last = CNT_W'(nv_q) - CNT_W'(1);

  // WLOAD runs one extra cycle so the last row's reload pulse lands before any DIN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    nv_d      = nv_q;
    w_rd_en_o = 1'b0;
    x_rd_en_o = 1'b0;
    done_o    = 1'b0;
    we_rl_d   = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_i) begin
          state_d = WLOAD;
          nv_d    = (num_vec_i > MAX_VEC) ? MAX_VEC : num_vec_i;
        end
      end
      WLOAD: begin
        w_rd_en_o = (cnt_q != WLOAD_LAST);
        if (cnt_q == WLOAD_LAST) begin
          cnt_d   = '0;
          state_d = (nv_q != '0) ? STREAM : DONE;
        end
      end
      STREAM: begin
        x_rd_en_o = 1'b1;
        if (cnt_q == nv_last) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    for (int r = 0; r < ARRAY_N; r++) begin
      we_rl_d[r] = w_rd_en_o && (cnt_q == CNT_W'(r));
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign we_rl_o     = we_rl_q;
  assign w_rd_addr_o = w_rd_en_o ? W_AW'(cnt_q) : '0;
  assign x_rd_addr_o = x_rd_en_o ? cnt_q[VEC_AW-1:0] : '0;

  skew_line #(
    .DEPTH(2 * ARRAY_N)
  ) u_skew (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .d_i   (x_rd_en_o),
    .taps_o(taps)
  );

  assign col_vld_o     = taps[ARRAY_N-1:0];
  assign row_out_vld_o = taps[2*ARRAY_N-1:ARRAY_N];

`ifdef SYSARR_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else if (state_q == IDLE && start_i) begin
      perf_q <= '0;
    end else if (busy_o && perf_q != '1) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_sysarr_ctrl.sv
// Scoreboard bench for sysarr_ctrl (ARRAY_N=4, VEC_AW=4); honours SYSARR_CTRL_PERF_EN.
module tb_sysarr_ctrl;

  localparam int N     = 4;
  localparam int VAW   = 4;
  localparam int WAW   = 3;
  localparam int MAXV  = 1 << VAW;
  localparam int NKIND = 6;

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } ev_t;

  logic           clk = 1'b0;
  logic           rst_i;
  logic           start_i;
  logic [VAW:0]   num_vec_i;
  logic           busy_o, done_o, w_rd_en_o, x_rd_en_o;
  logic [WAW-1:0] w_rd_addr_o;
  logic [N-1:0]   we_rl_o, col_vld_o, row_out_vld_o;
  logic [VAW-1:0] x_rd_addr_o;
  logic [31:0]    perf_cycles_o;

  int  cyc = 0;
  int  nVectors = 0;
  int  nMiscompares = 0;
  bit  monEn = 1'b0;
  int  busyFrom = 1;
  int  busyTo = 0;
  int  lastStart = 0;
  int  lastDone = 0;
  ev_t evQ[NKIND][$];

  sysarr_ctrl #(
    .ARRAY_N(N),
    .VEC_AW (VAW),
    .W_AW   (WAW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .num_vec_i    (num_vec_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .w_rd_en_o    (w_rd_en_o),
    .w_rd_addr_o  (w_rd_addr_o),
    .we_rl_o      (we_rl_o),
    .x_rd_en_o    (x_rd_en_o),
    .x_rd_addr_o  (x_rd_addr_o),
    .col_vld_o    (col_vld_o),
    .row_out_vld_o(row_out_vld_o),
    .perf_cycles_o(perf_cycles_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kindName(input int k);
    case (k)
      0: return "w_rd";
      1: return "we_rl";
      2: return "x_rd";
      3: return "col_vld";
      4: return "row_out_vld";
      default: return "done";
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s cycle %0d: got %0h required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic pushEv(input int k, input int c, input logic [31:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    evQ[k].push_back(e);
  endtask

  // Expected timeline for a job whose start is sampled at the end of cycle s.
  task automatic scheduleJob(input int s, input int nv);
    int nvEff, f, l, d;
    logic [31:0] v;
    nvEff = (nv > MAXV) ? MAXV : nv;
    for (int r = 0; r < N; r++) begin
      pushEv(0, s + 1 + r, 32'(r));
      pushEv(1, s + 2 + r, 32'(1) << r);
    end
    if (nvEff == 0) begin
      d = s + N + 2;
    end else begin
      f = s + N + 2;
      l = f + nvEff - 1;
      for (int k = 0; k < nvEff; k++) pushEv(2, f + k, 32'(k));
      for (int c = f + 1; c <= l + N; c++) begin
        v = '0;
        for (int j = 0; j < N; j++) if (c - 1 - j >= f && c - 1 - j <= l) v[j] = 1'b1;
        pushEv(3, c, v);
      end
      for (int c = f + N + 1; c <= l + 2 * N; c++) begin
        v = '0;
        for (int i = 0; i < N; i++) if (c - 1 - N - i >= f && c - 1 - N - i <= l) v[i] = 1'b1;
        pushEv(4, c, v);
      end
      d = l + 2 * N + 1;
    end
    pushEv(5, d, 32'd1);
    busyFrom  = s + 1;
    busyTo    = d;
    lastStart = s;
    lastDone  = d;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitCycle(input int t);
    while (cyc < t) nextCycle();
  endtask

  task automatic applyStimulus(input int nv, input bit expectAccept);
    start_i   = 1'b1;
    num_vec_i = (VAW + 1)'(nv);
    if (expectAccept) scheduleJob(cyc, nv);
    nextCycle();
    start_i   = 1'b0;
    num_vec_i = '0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"}, 32'(busy_o), 32'd0);
    checkOutput({tag, " done"}, 32'(done_o), 32'd0);
    checkOutput({tag, " w_rd_en"}, 32'(w_rd_en_o), 32'd0);
    checkOutput({tag, " w_rd_addr"}, 32'(w_rd_addr_o), 32'd0);
    checkOutput({tag, " we_rl"}, 32'(we_rl_o), 32'd0);
    checkOutput({tag, " x_rd_en"}, 32'(x_rd_en_o), 32'd0);
    checkOutput({tag, " x_rd_addr"}, 32'(x_rd_addr_o), 32'd0);
    checkOutput({tag, " col_vld"}, 32'(col_vld_o), 32'd0);
    checkOutput({tag, " row_out_vld"}, 32'(row_out_vld_o), 32'd0);
  endtask

  task automatic monKind(input int k, input bit active, input logic [31:0] val);
    ev_t e;
    while (evQ[k].size() != 0 && evQ[k][0].cyc < cyc) begin
      e = evQ[k].pop_front();
      nVectors++;
      nMiscompares++;
      $display("[TB] FAIL %s missed at cycle %0d: got inactive required %0h", kindName(k), e.cyc, e.val);
    end
    if (active) begin
      if (evQ[k].size() != 0 && evQ[k][0].cyc == cyc) begin
        e = evQ[k].pop_front();
        checkOutput(kindName(k), val, e.val);
      end else begin
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL %s unexpected at cycle %0d: got %0h required inactive", kindName(k), cyc, val);
      end
    end
  endtask

  // Monitor: pops expected events whenever the DUT presents activity.
  always @(negedge clk) begin
    if (monEn) begin
      monKind(0, w_rd_en_o, 32'(w_rd_addr_o));
      monKind(1, we_rl_o != '0, 32'(we_rl_o));
      monKind(2, x_rd_en_o, 32'(x_rd_addr_o));
      monKind(3, col_vld_o != '0, 32'(col_vld_o));
      monKind(4, row_out_vld_o != '0, 32'(row_out_vld_o));
      monKind(5, done_o, 32'(done_o));
      checkOutput("busy", 32'(busy_o), 32'(cyc >= busyFrom && cyc <= busyTo));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s1, d1, r0;
    logic [31:0] perfExp;
    rst_i     = 1'b1;
    start_i   = 1'b0;
    num_vec_i = '0;
    nextCycle();
    nextCycle();
    nextCycle();
    checkAllZero("reset");
    checkOutput("reset perf", perf_cycles_o, 32'd0);
    rst_i = 1'b0;
    nextCycle();
    monEn = 1'b1;
    checkAllZero("idle");

    applyStimulus(0, 1'b1);
    waitCycle(lastDone + 2);

    applyStimulus(3, 1'b1);
    s1 = lastStart;
    d1 = lastDone;
    waitCycle(s1 + N + 3);
    applyStimulus(2, 1'b0);
    waitCycle(d1);
    applyStimulus(1, 1'b0);
`ifdef SYSARR_CTRL_PERF_EN
    perfExp = 32'd17;
`else
    perfExp = 32'd0;
`endif
    checkOutput("perf_cycles", perf_cycles_o, perfExp);
    applyStimulus(2, 1'b1);
    waitCycle(lastDone + 2);

    applyStimulus(MAXV, 1'b1);
    waitCycle(lastDone + 2);

    applyStimulus(31, 1'b1);
    waitCycle(lastDone + 2);

    applyStimulus(5, 1'b1);
    waitCycle(lastStart + N + 4);
    r0    = cyc;
    rst_i = 1'b1;
    for (int k = 0; k < NKIND; k++) begin
      while (evQ[k].size() != 0 && evQ[k][$].cyc > r0) void'(evQ[k].pop_back());
    end
    busyTo = r0;
    nextCycle();
    checkAllZero("midreset");
    nextCycle();
    nextCycle();
    rst_i = 1'b0;
    nextCycle();

    applyStimulus(1, 1'b1);
    waitCycle(lastDone + 4);

    for (int k = 0; k < NKIND; k++) begin
      checkOutput({kindName(k), " leftover"}, 32'(evQ[k].size()), 32'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
